tdi_ahb_master_p: RTL and testbench
===================================

Name: tdi_ahb_master_p

Overview:
- Parametrised next-generation two-wire debug port (SCK/SDI/SDO/SDOE) acting as an AHB-Lite master for an on-chip debugger.
- SCK and SDI are synchronised into the HCLK domain; commands, addresses and data are shifted LSB-first.
- Adds configurable data/address width, bus-error reporting and an optional auto-increment burst mode.

Parameters:
- DATA_W, 32: bus/serial data word width; legal values 8, 16, 32.
- ADDR_W, 32: address field width, shifted serially; legal range 8..32.
- ID_CODE, 8'h5A: value returned by command 0xA1.
- VERSION, 16'h0201: value returned by command 0xA2.
- SYNC_STAGES, 2: flop stages on SCK and SDI; minimum 2.

Ports:
- HCLK  in  1  system clock
- HRESET  in  1  asynchronous, active-high reset
- SCK  in  1  serial clock, asynchronous; frequency must be <= HCLK/4
- SDI  in  1  serial data in; sampled on SCK rising edge
- SDO  out  1  serial data out; updated on SCK falling edge
- SDOE  out  1  SDO output enable
- HALT  out  1  core halt request
- HADDR  out  ADDR_W  AHB address
- HTRANS  out  2  IDLE (00) or NONSEQ (10) only
- HWRITE  out  1  AHB write
- HSIZE  out  3  log2(DATA_W/8)
- HWDATA  out  DATA_W  AHB write data
- HRDATA  in  DATA_W  AHB read data
- HREADY  in  1  AHB ready
- HRESP  in  1  AHB error

Behaviour:
- Reset (async, HRESET=1): SDO=0, SDOE=0, HALT=0, HTRANS=IDLE, HWRITE=0, HADDR=0, HWDATA=0, status=0, FSM=CMD.
- Edge detection: rising/falling edges of SCK are detected on the last two synchronised SCK samples; each edge is one HCLK-cycle pulse. SDI is captured from the synchronised sample on a rise pulse.
- FSM states: CMD, ADDR, CNT, WDATA, BUS_A, BUS_D, RDATA, RESP.
- CMD: shifts 8 bits. On the 8th rise the command is decoded:
  - A1: RESP with an 8-bit response of ID_CODE.
  - A2: RESP with a 16-bit response of VERSION.
  - A4: set HALT, then RESP with 8-bit status.
  - A5: clear HALT, then RESP with 8-bit status.
  - A8 (read) / A9 (write): go to ADDR.
  - AA / AB: burst commands, see Optional Feature.
  - Any other code: sets status[2] (bad_cmd) and returns to CMD.
- ADDR: shifts ADDR_W bits.
  - Read: go to BUS_A.
  - Write: go to WDATA, which shifts DATA_W bits, then BUS_A.
- BUS_A: one HCLK cycle with HTRANS=NONSEQ and HADDR/HWRITE valid; HWDATA is valid from the following cycle.
- BUS_D: HTRANS=IDLE; wait for HREADY=1.
  - Read: HRDATA is captured into the shifter, then go to RDATA.
  - Write: return to CMD.
  - HRESP=1 at completion sets status[1] (bus_err); for a read the data are still shifted out.
- RDATA / RESP: SDOE=1. Bit 0 is driven immediately on entry; each subsequent fall shifts out the next bit. After the last rise: SDOE=0 and return to CMD.
- Status byte: {5'b0, bad_cmd, bus_err, HALT}. bus_err and bad_cmd clear after the status byte has been read.
- Bus latency: the read is issued 1 HCLK after the last address bit. The host must wait for the bus before clocking read data; SCK edges arriving during BUS_A/BUS_D are ignored.
- Simultaneous events: a rise pulse and HREADY in the same cycle are both processed, with the FSM update taking priority order BUS > shift.
- Reset mid-transfer: the bus transfer is abandoned (HTRANS=IDLE) and partial shifts are discarded.

Optional Feature:
- Macro: TDI_BURST_EN.
- Defined:
  - AA = burst write: ADDR, then CNT (8-bit N, where N=0 means 256), then N x (WDATA, BUS_A, BUS_D).
  - AB = burst read: ADDR, CNT, then N x (BUS_A, BUS_D, RDATA).
  - HADDR increments by DATA_W/8 after each beat, wrapping modulo 2^ADDR_W.
  - A bus_err does not stop the burst.
- Undefined: AA and AB decode as bad commands; the CNT state and the beat counter are not present.

Decomposition:
- Package tdi_pkg:
  - command codes (CMD_ID=8'hA1, CMD_VER=8'hA2, CMD_HALT=8'hA4, CMD_RESUME=8'hA5, CMD_READ=8'hA8, CMD_WRITE=8'hA9, CMD_BWR=8'hAA, CMD_BRD=8'hAB);
  - FSM state enum;
  - HTRANS constants;
  - status bit indices.
- Sub-module tdi_sck_sync: SYNC_STAGES synchroniser for SCK/SDI, producing rise/fall pulses and the sampled SDI.

Test Plan:
- Send A1, read 8 bits -> 0x5A, SDOE high only during the read. Send A2, read 16 bits -> 0x0201.
- A9, addr 0xABCD1234, data 0xDEAD5555 -> one NONSEQ cycle with HADDR=0xABCD1234, HWRITE=1, HSIZE=2, then HWDATA=0xDEAD5555; slave inserts 3 wait states -> HTRANS stays IDLE.
- A8, addr 0xABCD4141, slave returns 0x12345678 with HRESP=1 -> read 32 bits = 0x12345678; then A4 + 8-bit read -> status 0x03, HALT=1; A5 + read -> 0x00, HALT=0.
- Send 0x77 -> A4 status read returns 0x05; reassert HRESET in the middle of a WDATA shift -> all outputs at reset values, next A1 works.
- TDI_BURST_EN: AB, addr 0x100, N=3 -> HADDR 0x100, 0x104, 0x108, three 32-bit words shifted out; AA with addr 0xFFFFFFFC, N=2 -> second beat HADDR=0x00000000.

Source files
------------

// File: rtl/tdi_pkg.sv
// tdi_pkg: command codes, FSM states, HTRANS encodings and status bit positions for the TDI debug port
package tdi_pkg;
    localparam logic [7:0] CMD_ID     = 8'hA1;
    localparam logic [7:0] CMD_VER    = 8'hA2;
    localparam logic [7:0] CMD_HALT   = 8'hA4;
    localparam logic [7:0] CMD_RESUME = 8'hA5;
    localparam logic [7:0] CMD_READ   = 8'hA8;
    localparam logic [7:0] CMD_WRITE  = 8'hA9;
    localparam logic [7:0] CMD_BWR    = 8'hAA;
    localparam logic [7:0] CMD_BRD    = 8'hAB;
    typedef enum logic [2:0] {
        ST_CMD, ST_ADDR, ST_CNT, ST_WDATA, ST_BUS_A, ST_BUS_D, ST_RDATA, ST_RESP
    } state_t;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam int STAT_HALT    = 0;
    localparam int STAT_BUS_ERR = 1;
    localparam int STAT_BAD_CMD = 2;
endpackage

// File: rtl/tdi_sck_sync.sv
// tdi_sck_sync: brings SCK/SDI into the HCLK domain and produces one-cycle SCK edge pulses
module tdi_sck_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sck,
    input  logic sdi,
    output logic rise,
    output logic fall,
    output logic sdi_s
);
    logic [SYNC_STAGES:0]   sck_q;
    logic [SYNC_STAGES-1:0] sdi_q;
    // Synchroniser chains; the extra SCK flop holds the previous synchronised sample for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_q <= '0;
            sdi_q <= '0;
        end else begin
            sck_q <= {sck_q[SYNC_STAGES-1:0], sck};
            sdi_q <= {sdi_q[SYNC_STAGES-2:0], sdi};
        end
    end
    assign rise  = sck_q[SYNC_STAGES-1] & ~sck_q[SYNC_STAGES];
    assign fall  = ~sck_q[SYNC_STAGES-1] & sck_q[SYNC_STAGES];
    assign sdi_s = sdi_q[SYNC_STAGES-1];
endmodule

// File: rtl/tdi_ahb_master_p.sv
// tdi_ahb_master_p: two-wire debug port driving an AHB-Lite master; TDI_BURST_EN adds auto-increment burst commands
module tdi_ahb_master_p
    import tdi_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 32,
    parameter logic [7:0]  ID_CODE     = 8'h5A,
    parameter logic [15:0] VERSION     = 16'h0201,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              SCK,
    input  logic              SDI,
    output logic              SDO,
    output logic              SDOE,
    output logic              HALT,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);
    localparam int MAX_AD = DATA_W > ADDR_W ? DATA_W : ADDR_W;
    localparam int SH_W = MAX_AD > 16 ? MAX_AD : 16;
    localparam logic [ADDR_W-1:0] INC = ADDR_W'(DATA_W / 8);
`ifdef TDI_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    state_t state, state_n;
    logic rise, fall, sdi_s, last, shift_st, bus_st, dec_ok, is_resp, bus_err, bad_cmd, stat_rd;
    logic bst, more_wr, more_rd;
    logic [5:0] cnt, len, resp_len;
    logic [SH_W-1:0] sh, sh_in;
    logic [7:0] byte_in, status, stat_ld;

    tdi_sck_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(HCLK), .rst(HRESET), .sck(SCK), .sdi(SDI), .rise(rise), .fall(fall), .sdi_s(sdi_s)
    );

    // Fields arrive LSB-first, so after n shifts a field sits in the top n bits of the shifter
    assign sh_in    = {sdi_s, sh[SH_W-1:1]};
    assign byte_in  = sh_in[SH_W-1 -: 8];
    assign shift_st = state inside {ST_CMD, ST_ADDR, ST_CNT, ST_WDATA};
    assign bus_st   = state inside {ST_BUS_A, ST_BUS_D};
    assign len      = state == ST_ADDR ? 6'(ADDR_W) :
                      state inside {ST_WDATA, ST_RDATA} ? 6'(DATA_W) :
                      state == ST_RESP ? resp_len : 6'd8;
    assign last     = cnt == len - 6'd1;
    assign is_resp  = byte_in inside {CMD_ID, CMD_VER, CMD_HALT, CMD_RESUME};
    assign dec_ok   = is_resp || byte_in inside {CMD_READ, CMD_WRITE} || (BURST && byte_in inside {CMD_BWR, CMD_BRD});
    assign SDOE     = state inside {ST_RDATA, ST_RESP};
    assign SDO      = SDOE & sh[0];
    assign HTRANS   = state == ST_BUS_A ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HSIZE    = 3'($clog2(DATA_W / 8));

    // Status byte now, and the version returned by HALT/RESUME carrying the new HALT value
    always_comb begin
        status = '0;
        status[STAT_HALT] = HALT;
        status[STAT_BUS_ERR] = bus_err;
        status[STAT_BAD_CMD] = bad_cmd;
        stat_ld = status;
        stat_ld[STAT_HALT] = byte_in == CMD_HALT;
    end

`ifdef TDI_BURST_EN
    logic [7:0] beats;
    assign more_wr = bst && beats != 8'd1;
    assign more_rd = bst && beats != 8'd0;
    // Burst flag per command and remaining-beat count (0 loads as 256 beats through wrap-around)
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            bst <= 1'b0;
            beats <= '0;
        end else if (state == ST_CMD && rise && last) bst <= byte_in inside {CMD_BWR, CMD_BRD};
        else if (state == ST_CNT && rise && last) beats <= byte_in;
        else if (state == ST_BUS_D && HREADY) beats <= beats - 8'd1;
    end
`else
    assign bst = 1'b0;
    assign more_wr = 1'b0;
    assign more_rd = 1'b0;
`endif

    // State register
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) state <= ST_CMD;
        else state <= state_n;
    end

    // Next state; SCK edges are ignored while the bus transfer is in flight
    always_comb begin
        state_n = state;
        case (state)
            ST_CMD:   if (rise && last) state_n = !dec_ok ? ST_CMD : is_resp ? ST_RESP : ST_ADDR;
            ST_ADDR:  if (rise && last) state_n = bst ? ST_CNT : HWRITE ? ST_WDATA : ST_BUS_A;
            ST_CNT:   if (rise && last) state_n = HWRITE ? ST_WDATA : ST_BUS_A;
            ST_WDATA: if (rise && last) state_n = ST_BUS_A;
            ST_BUS_A: state_n = ST_BUS_D;
            ST_BUS_D: if (HREADY) state_n = !HWRITE ? ST_RDATA : more_wr ? ST_WDATA : ST_CMD;
            ST_RDATA: if (rise && last) state_n = more_rd ? ST_BUS_A : ST_CMD;
            default:  if (rise && last) state_n = ST_CMD;
        endcase
    end

    // Shifter, bit counter, status flags and AHB address/data registers
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            cnt <= '0;
            sh <= '0;
            resp_len <= 6'd8;
            stat_rd <= 1'b0;
            HALT <= 1'b0;
            bus_err <= 1'b0;
            bad_cmd <= 1'b0;
            HADDR <= '0;
            HWRITE <= 1'b0;
            HWDATA <= '0;
        end else begin
            if (rise && !bus_st) cnt <= last ? '0 : cnt + 6'd1;
            if (rise && shift_st) sh <= sh_in;
            if (fall && SDOE && cnt != '0) sh <= sh >> 1;
            if (state == ST_CMD && rise && last) begin
                if (!dec_ok) bad_cmd <= 1'b1;
                if (byte_in == CMD_HALT) HALT <= 1'b1;
                if (byte_in == CMD_RESUME) HALT <= 1'b0;
                if (is_resp) begin
                    sh <= byte_in == CMD_ID ? SH_W'(ID_CODE) : byte_in == CMD_VER ? SH_W'(VERSION) : SH_W'(stat_ld);
                    resp_len <= byte_in == CMD_VER ? 6'd16 : 6'd8;
                    stat_rd <= byte_in inside {CMD_HALT, CMD_RESUME};
                end
                if (dec_ok && !is_resp) HWRITE <= byte_in inside {CMD_WRITE, CMD_BWR};
            end
            if (state == ST_ADDR && rise && last) HADDR <= sh_in[SH_W-1 -: ADDR_W];
            if (state == ST_BUS_A && HWRITE) HWDATA <= sh[SH_W-1 -: DATA_W];
            if (state == ST_BUS_D && HREADY) begin
                if (HRESP) bus_err <= 1'b1;
                if (!HWRITE) sh <= SH_W'(HRDATA);
                if (bst) HADDR <= HADDR + INC;
            end
            if (state == ST_RESP && rise && last && stat_rd) begin
                bus_err <= 1'b0;
                bad_cmd <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tdi_ahb_master_p.sv
// tb_tdi_ahb_master_p: directed scoreboard bench for the TDI debug port AHB master
module tb_tdi_ahb_master_p;
    logic HCLK = 1'b0, HRESET = 1'b1, SCK = 1'b0, SDI = 1'b0;
    logic SDO, SDOE, HALT, HWRITE;
    logic [31:0] HADDR, HWDATA;
    logic [1:0] HTRANS;
    logic [2:0] HSIZE;
    logic [31:0] HRDATA = '0;
    logic HREADY = 1'b1, HRESP = 1'b0;

    typedef struct {logic [31:0] a; logic w; logic [31:0] d;} beat_t;
    beat_t bus_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] rsp_q[$];
    int nchk = 0, nerr = 0, nonseq = 0, ws = 0, wcnt = 0;
    logic pend_w = 1'b0;
    logic [31:0] pend_d = '0;

    tdi_ahb_master_p dut (
        .HCLK(HCLK), .HRESET(HRESET), .SCK(SCK), .SDI(SDI), .SDO(SDO), .SDOE(SDOE), .HALT(HALT),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bus monitor and slave: checks each NONSEQ against the scoreboard, returns read data, inserts wait states
    always @(negedge HCLK) begin
        if (pend_w) begin
            chk("hwdata", HWDATA, pend_d);
            pend_w = 1'b0;
        end
        if (HTRANS == 2'b10) begin
            nonseq++;
            chk("nonseq_expected", {31'b0, bus_q.size() != 0}, 32'd1);
            if (bus_q.size() != 0) begin
                beat_t e;
                e = bus_q.pop_front();
                chk("haddr", HADDR, e.a);
                chk("hwrite", {31'b0, HWRITE}, {31'b0, e.w});
                chk("hsize", {29'b0, HSIZE}, 32'd2);
                if (e.w) begin
                    pend_w = 1'b1;
                    pend_d = e.d;
                end else HRDATA = rd_q.size() != 0 ? rd_q.pop_front() : '0;
            end
            wcnt = ws;
            HREADY = ws == 0;
        end else if (wcnt > 0) begin
            chk("htrans_idle_wait", {30'b0, HTRANS}, 32'd0);
            wcnt--;
            HREADY = wcnt == 0;
        end
    end

    task automatic xfer(input logic b, output logic o, output logic oe);
        SDI = b;
        repeat (4) @(negedge HCLK);
        o = SDO;
        oe = SDOE;
        SCK = 1'b1;
        repeat (4) @(negedge HCLK);
        SCK = 1'b0;
    endtask

    task automatic send(input logic [31:0] v, input int n);
        logic o, oe;
        for (int i = 0; i < n; i++) xfer(v[i], o, oe);
    endtask

    task automatic recv(input string tag, input int n);
        logic [31:0] v, exp;
        logic o, oe, oe_all;
        v = '0;
        oe_all = 1'b1;
        for (int i = 0; i < n; i++) begin
            xfer(1'b0, o, oe);
            v[i] = o;
            oe_all &= oe;
        end
        exp = rsp_q.size() != 0 ? rsp_q.pop_front() : 32'hxxxx_xxxx;
        chk(tag, v, exp);
        chk({tag, "_sdoe_during"}, {31'b0, oe_all}, 32'd1);
        repeat (4) @(negedge HCLK);
        chk({tag, "_sdoe_after"}, {31'b0, SDOE}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sdo"}, {31'b0, SDO}, 32'd0);
        chk({tag, "_sdoe"}, {31'b0, SDOE}, 32'd0);
        chk({tag, "_halt"}, {31'b0, HALT}, 32'd0);
        chk({tag, "_htrans"}, {30'b0, HTRANS}, 32'd0);
        chk({tag, "_hwrite"}, {31'b0, HWRITE}, 32'd0);
        chk({tag, "_haddr"}, HADDR, 32'd0);
        chk({tag, "_hwdata"}, HWDATA, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        repeat (3) @(negedge HCLK);
        check_reset_outputs("por");
        HRESET = 1'b0;
        repeat (3) @(negedge HCLK);
        // identification and version
        rsp_q.push_back(32'h5A);
        send(32'hA1, 8);
        recv("id", 8);
        rsp_q.push_back(32'h0201);
        send(32'hA2, 8);
        recv("version", 16);
        // single write with three wait states
        n0 = nonseq;
        ws = 3;
        bus_q.push_back('{32'hABCD1234, 1'b1, 32'hDEAD5555});
        send(32'hA9, 8);
        send(32'hABCD1234, 32);
        send(32'hDEAD5555, 32);
        repeat (12) @(negedge HCLK);
        chk("write_one_nonseq", nonseq - n0, 32'd1);
        chk("write_bus_q_drained", bus_q.size(), 32'd0);
        // single read completing with an error response
        ws = 0;
        HRESP = 1'b1;
        rd_q.push_back(32'h12345678);
        bus_q.push_back('{32'hABCD4141, 1'b0, 32'h0});
        rsp_q.push_back(32'h12345678);
        send(32'hA8, 8);
        send(32'hABCD4141, 32);
        repeat (8) @(negedge HCLK);
        recv("read_data", 32);
        HRESP = 1'b0;
        // halt / resume with status readback
        rsp_q.push_back(32'h03);
        send(32'hA4, 8);
        recv("status_halt_buserr", 8);
        chk("halt_set", {31'b0, HALT}, 32'd1);
        rsp_q.push_back(32'h00);
        send(32'hA5, 8);
        recv("status_cleared", 8);
        chk("halt_clear", {31'b0, HALT}, 32'd0);
        // unknown command then status
        send(32'h77, 8);
        rsp_q.push_back(32'h05);
        send(32'hA4, 8);
        recv("status_bad_cmd", 8);
`ifndef TDI_BURST_EN
        send(32'hAA, 8);
        rsp_q.push_back(32'h05);
        send(32'hA4, 8);
        recv("status_burst_is_bad", 8);
`endif
        // reset in the middle of a write-data shift
        send(32'hA9, 8);
        send(32'h55, 32);
        send(32'h3, 10);
        HRESET = 1'b1;
        repeat (2) @(negedge HCLK);
        check_reset_outputs("midrst");
        HRESET = 1'b0;
        repeat (3) @(negedge HCLK);
        rsp_q.push_back(32'h5A);
        send(32'hA1, 8);
        recv("id_after_reset", 8);
        rsp_q.push_back(32'h00);
        send(32'hA5, 8);
        recv("status_after_reset", 8);
`ifdef TDI_BURST_EN
        // burst read of three words
        for (int b = 0; b < 3; b++) begin
            rd_q.push_back(32'hC0DE_0000 + 32'(b * 17));
            rsp_q.push_back(32'hC0DE_0000 + 32'(b * 17));
            bus_q.push_back('{32'h100 + 32'(b * 4), 1'b0, 32'h0});
        end
        send(32'hAB, 8);
        send(32'h100, 32);
        send(32'h3, 8);
        for (int b = 0; b < 3; b++) begin
            repeat (8) @(negedge HCLK);
            recv("burst_read_word", 32);
        end
        chk("burst_read_drained", bus_q.size(), 32'd0);
        // burst write wrapping the address space
        bus_q.push_back('{32'hFFFFFFFC, 1'b1, 32'h1111_2222});
        bus_q.push_back('{32'h00000000, 1'b1, 32'h3333_4444});
        send(32'hAA, 8);
        send(32'hFFFFFFFC, 32);
        send(32'h2, 8);
        send(32'h1111_2222, 32);
        repeat (8) @(negedge HCLK);
        send(32'h3333_4444, 32);
        repeat (8) @(negedge HCLK);
        chk("burst_write_drained", bus_q.size(), 32'd0);
        rsp_q.push_back(32'h5A);
        send(32'hA1, 8);
        recv("id_after_burst", 8);
`endif
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
